fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the RISC-V core, sitting directly upstream of decode. It generates sequential PCs and issues reads to a synchronous instruction memory with fixed one-cycle latency. Returned words are buffered in a small prefetch queue and handed to decode over a valid/ready handshake. A redirect (branch/jump taken) flushes all buffered and in-flight fetches and restarts at the new PC.

## Interface
- `XLEN`, 32, data/address width.
- `RESET_PC`, 32'h0000_0000, first fetch address after reset.
- `DEPTH`, 2, prefetch queue entries (power of two, ≥2).

- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `imem_req`  out  1  read strobe to instruction memory.
- `imem_addr`  out  XLEN  word-aligned read address, valid when `imem_req`=1.
- `imem_rdata`  in  32  instruction word, valid exactly one cycle after `imem_req`.
- `redirect_valid`  in  1  flush and restart fetch.
- `redirect_pc`  in  XLEN  restart address; bits [1:0] ignored and treated as 0.
- `if_valid`  out  1  queue head holds an instruction for decode.
- `if_ready`  in  1  decode accepts the head this cycle.
- `if_pc`  out  XLEN  PC of head instruction.
- `if_instr`  out  32  head instruction word.
- `if_count`  out  $clog2(DEPTH)+1  current queue occupancy.

## Operation
- State: `fetch_pc`, `inflight` flag plus `inflight_pc`, queue of {pc, instr} with read/write pointers and count.
- `pop` = `if_valid` & `if_ready`.
- Issue: `imem_req` = !`redirect_valid` & (count + `inflight` − `pop` < DEPTH). On issue: `imem_addr` = `fetch_pc`, `inflight_pc` ← `fetch_pc`, `fetch_pc` ← `fetch_pc` + 4 (mod 2^XLEN, wraps silently), `inflight` ← 1. With no issue, `inflight` ← 0.
- Response: if `inflight`=1 and no redirect, push {`inflight_pc`, `imem_rdata`}. The credit rule guarantees space, so push never overflows.
- Push and pop may occur in the same cycle. Count is unchanged in that case.
- `if_valid` = (count ≠ 0) & !`redirect_valid`. `if_pc`/`if_instr` reflect the head entry directly from the queue registers.
- Redirect (`redirect_valid`=1):
  - Queue count and pointers reset to 0.
  - The in-flight response is discarded (not pushed).
  - `inflight` ← 0.
  - `fetch_pc` ← {`redirect_pc`[XLEN−1:2], 2'b00}.
  - No request is issued this cycle.
  - Any pop is suppressed this cycle, because `if_valid` is low.
- Redirect has priority over every other event, including simultaneous push, pop and a full queue.

## Timing
- Reset values:
  - `fetch_pc`=RESET_PC; count=0; `inflight`=0.
  - `imem_req`=0 while `rst`=0.
  - `if_valid`=0, `if_count`=0.
  - `if_pc`/`if_instr`=0 (queue storage cleared).
- First request is made in the first clock edge cycle after `rst` deasserts.
- Fetch-to-decode latency: request in cycle N, data at N+1, `if_valid` at N+2.
- Redirect latency: redirect asserted in cycle R; request to the new PC in R+1; `if_valid` with the new PC in R+3.
- Throughput: with `if_ready` held high, one instruction per cycle in steady state.
- Backpressure: with `if_ready`=0, issue stops once count + `inflight` = DEPTH. Head outputs hold stable until popped.
- Reset mid-operation: the asynchronous clear takes effect immediately. Any pending memory response is ignored.

## Test plan
- Reset release, `if_ready`=1, memory returns addr-based words. Required: `if_valid` rises 2 cycles after the first request; PCs appear 0x0, 0x4, 0x8… one per cycle with matching words.
- Hold `if_ready`=0 for 6 cycles. Required: `if_count` saturates at 2 and `imem_req` drops. On release, PCs continue in order with no gap or duplicate.
- Redirect to 0x100 while the queue is full and a request is in flight. Required: `if_valid` is 0 in the redirect cycle; next `if_pc`=0x100, seen 3 cycles later; no stale PC is ever delivered.
- Redirect to 0x203. Required: the request goes to 0x200 and `if_pc`=0x200.
- Redirect in the same cycle as a pop and a push. Required: neither is observed, and the queue ends empty.
- Assert `rst`=0 mid-stream. Required: outputs clear asynchronously; after release, fetch restarts at RESET_PC.
- `fetch_pc` near 0xFFFF_FFFC: required next PC is 0x0000_0000.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: generates sequential PCs, issues one-cycle-latency instruction
// memory reads and buffers returned words in a small queue for decode.
// A redirect flushes buffered and in-flight fetches and restarts at a new PC.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    imem_req,
    output logic [XLEN-1:0]         imem_addr,
    input  logic [31:0]             imem_rdata,
    input  logic                    redirect_valid,
    input  logic [XLEN-1:0]         redirect_pc,
    output logic                    if_valid,
    input  logic                    if_ready,
    output logic [XLEN-1:0]         if_pc,
    output logic [31:0]             if_instr,
    output logic [$clog2(DEPTH):0]  if_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    // Depth in the widened occupancy width, so the credit compare is width-matched.
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
    logic [XLEN-1:0] pc_q [DEPTH];
    logic [XLEN-1:0] pc_d [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [31:0]     instr_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            pop;
    logic            push;
    logic            issue;
    logic [CW:0]     occupancy;

    // Handshake, credit check and head-of-queue outputs.
    always_comb begin
        if_valid  = (count_q != '0) && !redirect_valid;
        pop       = if_valid && if_ready;
        push      = inflight_q && !redirect_valid;
        // Entries held plus the one still coming back, minus the one leaving now.
        occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
        // rst gating keeps the strobe low while the asynchronous reset is held.
        issue     = rst && !redirect_valid && (occupancy < DEPTH_W);
        imem_req  = issue;
        imem_addr = fetch_pc_q;
        if_pc     = pc_q[rd_ptr_q];
        if_instr  = instr_q[rd_ptr_q];
        if_count  = count_q;
    end

    // Next-state: redirect flushes everything; otherwise issue, push and pop.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ALIGN_MASK;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                inflight_pc_d = fetch_pc_q;
                fetch_pc_d    = fetch_pc_q + XLEN'(4);
            end
            if (push) begin
                pc_d[wr_ptr_q]    = inflight_pc_q;
                instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d          = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // State registers; reset also clears queue storage so head outputs read zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives fetch_unit against a one-cycle memory model and checks
// the delivered {pc, instr} stream against a queue of expected entries.
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            imem_req;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_rdata;
    logic            redirect_valid = 1'b0;
    logic [31:0]     redirect_pc = 32'h0;
    logic            if_valid;
    logic            if_ready = 1'b0;
    logic [31:0]     if_pc;
    logic [31:0]     if_instr;
    logic [CW-1:0]   if_count;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_e;
    logic [31:0] hold_pc;

    fetch_unit #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
        .if_instr(if_instr), .if_count(if_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0F0F_3C3C;
    endfunction

    // Memory: word for the requested address one cycle later, junk otherwise.
    always @(posedge clk) imem_rdata <= imem_req ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    // Expected stream restarts at a new PC: drop old expectations, queue sequential ones.
    task automatic sb_start(input logic [31:0] start);
        logic [31:0] p;
        sb.delete();
        p = start;
        for (int i = 0; i < 64; i++) begin
            sb.push_back({p, instr_of(p)});
            p = p + 32'd4;
        end
    endtask

    // Every accepted head is compared against the front of the expectation queue.
    always @(negedge clk) begin
        if (if_valid && if_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got pc=%h instr=%h, expected no delivery", if_pc, if_instr);
            end else begin
                exp_e = sb.pop_front();
                if ({if_pc, if_instr} !== exp_e) begin
                    errors++;
                    $display("FAIL sb_deliver got pc=%h instr=%h expected pc=%h instr=%h",
                             if_pc, if_instr, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b0; if_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b expected 0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", if_valid); end
        checks++; if (if_count !== '0) begin errors++; $display("FAIL reset_count got %0d expected 0", if_count); end
        checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h expected 0", if_pc); end
        checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h expected 0", if_instr); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h expected 0", imem_addr); end
    endtask

    task automatic test_stream();
        sb_start(32'h0);
        @(posedge clk); #1; rst = 1'b1; if_ready = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_early got %b expected 0", if_valid); end
        checks++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL stream_second_addr got %h expected 4", imem_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin errors++; $display("FAIL stream_first_valid got valid=%b pc=%h expected 1/0", if_valid, if_pc); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_throughput cycle %0d got valid=%b expected 1", i, if_valid); end
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1; if_ready = 1'b0;
        @(negedge clk);
        hold_pc = if_pc;
        repeat (5) @(negedge clk);
        checks++; if (if_count !== CW'(2)) begin errors++; $display("FAIL bp_count got %0d expected 2", if_count); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req got %b expected 0", imem_req); end
        checks++; if (if_valid !== 1'b1 || if_pc !== hold_pc) begin errors++; $display("FAIL bp_hold got valid=%b pc=%h expected 1/%h", if_valid, if_pc, hold_pc); end
        @(posedge clk); #1; if_ready = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_redirect_full();
        @(posedge clk); #1; if_ready = 1'b0;
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h100; if_ready = 1'b1;
        sb_start(32'h100);
        @(negedge clk);
        checks++; if (if_count !== CW'(2)) begin errors++; $display("FAIL rfull_pre_count got %0d expected 2", if_count); end
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rfull_cycle got valid=%b req=%b expected 0/0", if_valid, imem_req); end
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (if_count !== '0) begin errors++; $display("FAIL rfull_flush got count=%0d expected 0", if_count); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rfull_req got req=%b addr=%h expected 1/100", imem_req, imem_addr); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rfull_r2_valid got %b expected 0", if_valid); end
        @(negedge clk);
        checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errors++; $display("FAIL rfull_r3 got valid=%b pc=%h expected 1/100", if_valid, if_pc); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_redirect_pop_push();
        @(negedge clk);
        checks++; if (if_count !== CW'(1) || imem_req !== 1'b1) begin errors++; $display("FAIL rpp_pre got count=%0d req=%b expected 1/1", if_count, imem_req); end
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'h203;
        sb_start(32'h200);
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rpp_cycle got valid=%b req=%b expected 0/0", if_valid, imem_req); end
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (if_count !== '0) begin errors++; $display("FAIL rpp_empty got count=%0d expected 0", if_count); end
        checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL rpp_align got addr=%h expected 200", imem_addr); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (if_pc !== 32'h200 || if_instr !== instr_of(32'h200)) begin errors++; $display("FAIL rpp_head got pc=%h instr=%h expected 200/%h", if_pc, if_instr, instr_of(32'h200)); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1; rst = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || if_count !== '0) begin errors++; $display("FAIL mid_clear got valid=%b count=%0d expected 0/0", if_valid, if_count); end
        checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL mid_head got pc=%h instr=%h expected 0/0", if_pc, if_instr); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b expected 0", imem_req); end
        repeat (2) @(posedge clk);
        #1; sb_start(32'h0); rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL mid_restart got req=%b addr=%h expected 1/0", imem_req, imem_addr); end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF9;
        sb_start(32'hFFFF_FFF8);
        @(posedge clk); #1; redirect_valid = 1'b0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_a0 got %h expected fffffff8", imem_addr); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_a1 got %h expected fffffffc", imem_addr); end
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0000_0000) begin errors++; $display("FAIL wrap_a2 got %h expected 00000000", imem_addr); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop_push();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
